// File: rtl/ffe_cfg_pkg.sv
// Shared configuration for the FFE tap controller: sizes, tap type,
// controller states and the reset image of the tap bank.
package ffe_cfg_pkg;

  localparam int NUM_TAPS   = 14;
  localparam int TAP_W      = 8;
  localparam int ADDR_W     = 4;
  localparam int CURSOR_IDX = 0;
  localparam int UNITY      = 64;

  typedef logic signed [TAP_W-1:0] tap_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BND,
    SWAP,
    FLUSH
  } state_t;

  // Reset value of a tap: unity on the cursor, zero everywhere else.
  function automatic tap_t default_tap(input int idx);
    return (idx == CURSOR_IDX) ? tap_t'(UNITY) : tap_t'(0);
  endfunction

endpackage

// File: rtl/ffe_tap_bank.sv
// Double-buffered tap storage: writes land in the shadow bank, and a swap
// copies the whole shadow bank into the active bank in one edge.
module ffe_tap_bank
  import ffe_cfg_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  tap_t              wr_data_i,
  input  logic              swap_i,
  output tap_t              active_o [NUM_TAPS]
);

  tap_t shadow_q [NUM_TAPS];
  tap_t shadow_d [NUM_TAPS];
  tap_t active_q [NUM_TAPS];
  tap_t active_d [NUM_TAPS];

  // Next bank contents: single-tap shadow update, whole-bank copy on swap.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (wr_en_i && (wr_addr_i == ADDR_W'(i))) shadow_d[i] = wr_data_i;
    end
    if (swap_i) active_d = shadow_q;
  end

  // Bank registers, both restored to the unity-cursor image on reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        shadow_q[i] <= default_tap(i);
        active_q[i] <= default_tap(i);
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/ffe_tap_controller.sv
// FFE tap controller: accepts shadow tap writes, swaps them into the active
// bank on a symbol-block boundary (or after a bounded wait), then masks the
// decoder valid while its pipeline flushes out mixed-tap symbols.
module ffe_tap_controller
  import ffe_cfg_pkg::*;
#(
  parameter int FLUSH_CYCLES = 4,
  parameter int MAX_WAIT     = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_wr_valid,
  output logic                    io_wr_ready,
  input  logic [ADDR_W-1:0]       io_wr_addr,
  input  logic signed [TAP_W-1:0] io_wr_data,
  input  logic                    io_commit,
  input  logic                    io_boundary,
  input  logic                    io_rxValid_in,
  output logic                    io_rxValid_out,
  output logic signed [TAP_W-1:0] io_taps_0,
  output logic signed [TAP_W-1:0] io_taps_1,
  output logic signed [TAP_W-1:0] io_taps_2,
  output logic signed [TAP_W-1:0] io_taps_3,
  output logic signed [TAP_W-1:0] io_taps_4,
  output logic signed [TAP_W-1:0] io_taps_5,
  output logic signed [TAP_W-1:0] io_taps_6,
  output logic signed [TAP_W-1:0] io_taps_7,
  output logic signed [TAP_W-1:0] io_taps_8,
  output logic signed [TAP_W-1:0] io_taps_9,
  output logic signed [TAP_W-1:0] io_taps_10,
  output logic signed [TAP_W-1:0] io_taps_11,
  output logic signed [TAP_W-1:0] io_taps_12,
  output logic signed [TAP_W-1:0] io_taps_13,
  output logic                    io_busy,
  output logic                    io_commit_done,
  output logic                    io_err
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                keep_q, keep_d;
  logic                swap;
  logic                forced;
  logic                wr_fire;
  logic                bad_wr;
  tap_t                active [NUM_TAPS];

  assign io_wr_ready = (state_q == IDLE) || (state_q == FLUSH);
  assign wr_fire     = io_wr_valid && io_wr_ready;
  assign bad_wr      = wr_fire && (io_wr_addr >= ADDR_W'(NUM_TAPS));

  // Commit sequencing: wait for a boundary (bounded), swap, then flush.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    swap        = 1'b0;
    forced      = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_commit) begin
          state_d    = WAIT_BND;
          wait_cnt_d = '0;
        end
      end
      WAIT_BND: begin
        if (io_boundary) begin
          state_d = SWAP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = SWAP;
          forced  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      SWAP: begin
        swap        = 1'b1;
        state_d     = FLUSH;
        flush_cnt_d = '0;
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky error: a completed commit clears it, except for errors raised
  // during that same commit, which survive until the following one.
  always_comb begin
    err_d  = err_q;
    keep_d = keep_q;
    if (done_q) begin
      err_d  = keep_q;
      keep_d = 1'b0;
    end
    if (bad_wr || forced) begin
      err_d = 1'b1;
      if (state_q != IDLE) keep_d = 1'b1;
    end
  end

  // Controller state, counters and flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      keep_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      keep_q      <= keep_d;
    end
  end

  ffe_tap_bank u_bank (
    .clock_i   (clock),
    .reset_i   (reset),
    .wr_en_i   (wr_fire && !bad_wr),
    .wr_addr_i (io_wr_addr),
    .wr_data_i (io_wr_data),
    .swap_i    (swap),
    .active_o  (active)
  );

  assign io_rxValid_out = io_rxValid_in && (state_q != FLUSH);
  assign io_busy        = (state_q != IDLE);
  assign io_commit_done = done_q;
  assign io_err         = err_q;

  assign io_taps_0  = active[0];
  assign io_taps_1  = active[1];
  assign io_taps_2  = active[2];
  assign io_taps_3  = active[3];
  assign io_taps_4  = active[4];
  assign io_taps_5  = active[5];
  assign io_taps_6  = active[6];
  assign io_taps_7  = active[7];
  assign io_taps_8  = active[8];
  assign io_taps_9  = active[9];
  assign io_taps_10 = active[10];
  assign io_taps_11 = active[11];
  assign io_taps_12 = active[12];
  assign io_taps_13 = active[13];

endmodule

// File: tb/tb_ffe_tap_controller.sv
// Directed bench for ffe_tap_controller: reset image, normal commit timing,
// writes during a pending commit, bad address, boundary timeout and reset
// during the flush window.
module tb_ffe_tap_controller;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_wr_valid;
  logic              io_wr_ready;
  logic [3:0]        io_wr_addr;
  logic signed [7:0] io_wr_data;
  logic              io_commit;
  logic              io_boundary;
  logic              io_rxValid_in;
  logic              io_rxValid_out;
  logic signed [7:0] io_taps_0, io_taps_1, io_taps_2, io_taps_3, io_taps_4;
  logic signed [7:0] io_taps_5, io_taps_6, io_taps_7, io_taps_8, io_taps_9;
  logic signed [7:0] io_taps_10, io_taps_11, io_taps_12, io_taps_13;
  logic              io_busy;
  logic              io_commit_done;
  logic              io_err;

  logic [7:0] tapObs  [14];
  logic [7:0] expTaps [14];
  int         checks   = 0;
  int         failures = 0;

  always #5 clock = ~clock;

  ffe_tap_controller #(.FLUSH_CYCLES(4), .MAX_WAIT(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_wr_valid    (io_wr_valid),
    .io_wr_ready    (io_wr_ready),
    .io_wr_addr     (io_wr_addr),
    .io_wr_data     (io_wr_data),
    .io_commit      (io_commit),
    .io_boundary    (io_boundary),
    .io_rxValid_in  (io_rxValid_in),
    .io_rxValid_out (io_rxValid_out),
    .io_taps_0      (io_taps_0),
    .io_taps_1      (io_taps_1),
    .io_taps_2      (io_taps_2),
    .io_taps_3      (io_taps_3),
    .io_taps_4      (io_taps_4),
    .io_taps_5      (io_taps_5),
    .io_taps_6      (io_taps_6),
    .io_taps_7      (io_taps_7),
    .io_taps_8      (io_taps_8),
    .io_taps_9      (io_taps_9),
    .io_taps_10     (io_taps_10),
    .io_taps_11     (io_taps_11),
    .io_taps_12     (io_taps_12),
    .io_taps_13     (io_taps_13),
    .io_busy        (io_busy),
    .io_commit_done (io_commit_done),
    .io_err         (io_err)
  );

  assign tapObs[0]  = io_taps_0;
  assign tapObs[1]  = io_taps_1;
  assign tapObs[2]  = io_taps_2;
  assign tapObs[3]  = io_taps_3;
  assign tapObs[4]  = io_taps_4;
  assign tapObs[5]  = io_taps_5;
  assign tapObs[6]  = io_taps_6;
  assign tapObs[7]  = io_taps_7;
  assign tapObs[8]  = io_taps_8;
  assign tapObs[9]  = io_taps_9;
  assign tapObs[10] = io_taps_10;
  assign tapObs[11] = io_taps_11;
  assign tapObs[12] = io_taps_12;
  assign tapObs[13] = io_taps_13;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkTaps(input string tag);
    for (int i = 0; i < 14; i++) begin
      checkOutput($sformatf("%s_tap%0d", tag, i), {8'h00, tapObs[i]}, {8'h00, expTaps[i]});
    end
  endtask

  // One accepted tap write while the port is ready.
  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
    io_wr_valid = 1'b1;
    io_wr_addr  = addr;
    io_wr_data  = data;
    tick();
    io_wr_valid = 1'b0;
  endtask

  // Bounded wait that leaves the bench inside the commit_done cycle.
  task automatic waitDone(input string tag);
    int guard = 0;
    #1;
    while (io_commit_done !== 1'b1 && guard < 30) begin
      tick();
      #1;
      guard++;
    end
    checkOutput(tag, {15'd0, io_commit_done}, 16'd1);
  endtask

  // Commit with the boundary arriving bnd cycles after the commit pulse.
  task automatic runCommit(input int bnd, input string tag);
    io_commit = 1'b1;
    tick();
    io_commit = 1'b0;
    repeat (bnd - 1) tick();
    io_boundary = 1'b1;
    tick();
    io_boundary = 1'b0;
    waitDone(tag);
  endtask

  initial begin
    logic doneSeen;
    reset         = 1'b1;
    io_wr_valid   = 1'b0;
    io_wr_addr    = '0;
    io_wr_data    = '0;
    io_commit     = 1'b0;
    io_boundary   = 1'b0;
    io_rxValid_in = 1'b1;
    for (int i = 0; i < 14; i++) expTaps[i] = 8'h00;
    expTaps[0] = 8'h40;
    repeat (3) tick();
    reset = 1'b0;
    #1;

    // Reset image
    checkTaps("rst");
    checkOutput("rst_busy",   {15'd0, io_busy},        16'd0);
    checkOutput("rst_ready",  {15'd0, io_wr_ready},    16'd1);
    checkOutput("rst_err",    {15'd0, io_err},         16'd0);
    checkOutput("rst_done",   {15'd0, io_commit_done}, 16'd0);
    checkOutput("rst_rxv",    {15'd0, io_rxValid_out}, 16'd1);

    // Normal commit: load {10,-3,2,0,...,0,-1}, commit at t, boundary at t+5
    tick();
    applyStimulus(4'd0, 8'h0A);
    applyStimulus(4'd1, 8'hFD);
    applyStimulus(4'd2, 8'h02);
    for (int i = 3; i < 13; i++) applyStimulus(4'(i), 8'h00);
    applyStimulus(4'd13, 8'hFF);
    io_commit = 1'b1;
    tick();                                            // t+1
    io_commit = 1'b0;
    #1;
    checkOutput("nc_busy_wait",  {15'd0, io_busy},     16'd1);
    checkOutput("nc_ready_wait", {15'd0, io_wr_ready}, 16'd0);
    repeat (4) tick();                                 // t+5
    io_boundary = 1'b1;
    #1;
    checkOutput("nc_tap0_t5", {8'h00, tapObs[0]}, 16'h0040);
    tick();                                            // t+6 SWAP
    io_boundary = 1'b0;
    #1;
    checkOutput("nc_tap0_t6", {8'h00, tapObs[0]}, 16'h0040);
    checkOutput("nc_rxv_swap", {15'd0, io_rxValid_out}, 16'd1);
    tick();                                            // t+7 FLUSH
    #1;
    expTaps[0] = 8'h0A; expTaps[1] = 8'hFD; expTaps[2] = 8'h02; expTaps[13] = 8'hFF;
    checkTaps("nc_new");
    checkOutput("nc_ready_flush", {15'd0, io_wr_ready}, 16'd1);
    for (int k = 7; k <= 10; k++) begin
      if (k != 7) begin
        tick();
        #1;
      end
      checkOutput($sformatf("nc_rxv_mask_t%0d", k), {15'd0, io_rxValid_out}, 16'd0);
      checkOutput($sformatf("nc_done_low_t%0d", k), {15'd0, io_commit_done}, 16'd0);
    end
    tick();                                            // t+11
    #1;
    checkOutput("nc_done_t11", {15'd0, io_commit_done}, 16'd1);
    checkOutput("nc_busy_t11", {15'd0, io_busy},        16'd0);
    checkOutput("nc_rxv_t11",  {15'd0, io_rxValid_out}, 16'd1);
    tick();                                            // t+12
    #1;
    checkOutput("nc_done_t12", {15'd0, io_commit_done}, 16'd0);

    // Write held valid while a commit is pending
    io_commit = 1'b1;
    tick();                                            // c+1 WAIT_BND
    io_commit   = 1'b0;
    io_wr_valid = 1'b1;
    io_wr_addr  = 4'd3;
    io_wr_data  = 8'h37;
    #1;
    checkOutput("ww_ready_wait", {15'd0, io_wr_ready}, 16'd0);
    tick();                                            // c+2
    io_boundary = 1'b1;
    tick();                                            // c+3 SWAP
    io_boundary = 1'b0;
    #1;
    checkOutput("ww_ready_swap", {15'd0, io_wr_ready}, 16'd0);
    tick();                                            // c+4 FLUSH
    #1;
    checkOutput("ww_ready_flush", {15'd0, io_wr_ready}, 16'd1);
    checkOutput("ww_tap3_flush", {8'h00, tapObs[3]}, 16'h0000);
    tick();                                            // c+5
    io_wr_valid = 1'b0;
    #1;
    checkOutput("ww_tap3_after", {8'h00, tapObs[3]}, 16'h0000);
    waitDone("ww_done1");
    tick();
    #1;
    checkTaps("ww_keep");
    runCommit(2, "ww_done2");
    tick();
    #1;
    expTaps[3] = 8'h37;
    checkTaps("ww_apply");

    // Out-of-range address
    io_wr_valid = 1'b1;
    io_wr_addr  = 4'd14;
    io_wr_data  = 8'h07;
    #1;
    checkOutput("ba_ready", {15'd0, io_wr_ready}, 16'd1);
    tick();
    io_wr_valid = 1'b0;
    #1;
    checkOutput("ba_err", {15'd0, io_err}, 16'd1);
    repeat (3) tick();
    #1;
    checkOutput("ba_err_hold", {15'd0, io_err}, 16'd1);
    runCommit(1, "ba_done");
    tick();
    #1;
    checkOutput("ba_err_clr", {15'd0, io_err}, 16'd0);
    checkTaps("ba_taps");

    // Boundary timeout: no boundary, forced swap after MAX_WAIT=8 cycles
    applyStimulus(4'd5, 8'h80);
    io_commit = 1'b1;
    tick();                                            // t+1
    io_commit = 1'b0;
    #1;
    checkOutput("to_err_start", {15'd0, io_err}, 16'd0);
    repeat (7) tick();                                 // t+8
    #1;
    checkOutput("to_busy_t8", {15'd0, io_busy},   16'd1);
    checkOutput("to_err_t8",  {15'd0, io_err},    16'd0);
    checkOutput("to_tap5_t8", {8'h00, tapObs[5]}, 16'h0000);
    tick();                                            // t+9 SWAP
    #1;
    checkOutput("to_err_t9",   {15'd0, io_err},      16'd1);
    checkOutput("to_ready_t9", {15'd0, io_wr_ready}, 16'd0);
    checkOutput("to_tap5_t9",  {8'h00, tapObs[5]},   16'h0000);
    tick();                                            // t+10
    #1;
    checkOutput("to_tap5_t10", {8'h00, tapObs[5]},      16'h0080);
    checkOutput("to_rxv_t10",  {15'd0, io_rxValid_out}, 16'd0);
    repeat (4) tick();                                 // t+14
    #1;
    checkOutput("to_done_t14", {15'd0, io_commit_done}, 16'd1);
    tick();                                            // t+15
    #1;
    checkOutput("to_done_t15", {15'd0, io_commit_done}, 16'd0);
    checkOutput("to_err_t15",  {15'd0, io_err},         16'd1);
    expTaps[5] = 8'h80;
    runCommit(3, "to_clr_done");
    tick();
    #1;
    checkOutput("to_err_clr", {15'd0, io_err}, 16'd0);

    // Reset during the second flush cycle
    applyStimulus(4'd1, 8'h21);
    io_commit = 1'b1;
    tick();                                            // WAIT_BND
    io_commit   = 1'b0;
    io_boundary = 1'b1;
    tick();                                            // SWAP
    io_boundary = 1'b0;
    tick();                                            // FLUSH 1
    #1;
    checkOutput("rf_tap1_f1", {8'h00, tapObs[1]},      16'h0021);
    checkOutput("rf_rxv_f1",  {15'd0, io_rxValid_out}, 16'd0);
    tick();                                            // FLUSH 2
    reset = 1'b1;
    #1;
    checkOutput("rf_rxv_f2", {15'd0, io_rxValid_out}, 16'd0);
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 14; i++) expTaps[i] = 8'h00;
    expTaps[0] = 8'h40;
    checkTaps("rf_def");
    checkOutput("rf_busy", {15'd0, io_busy},        16'd0);
    checkOutput("rf_rxv",  {15'd0, io_rxValid_out}, 16'd1);
    checkOutput("rf_err",  {15'd0, io_err},         16'd0);
    doneSeen = io_commit_done;
    for (int k = 0; k < 8; k++) begin
      tick();
      #1;
      doneSeen = doneSeen | io_commit_done;
    end
    checkOutput("rf_no_done", {15'd0, doneSeen}, 16'd0);
    io_rxValid_in = 1'b0;
    #1;
    checkOutput("rf_rxv_follow", {15'd0, io_rxValid_out}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ffe_tap_controller.md
Name: ffe_tap_controller

Overview:
Owns the 14 FFE tap coefficients driven into FFE_Decoder. Software or an adaptation engine writes new taps one at a time into a shadow bank through a valid/ready port. A commit request then swaps the shadow bank into the active bank atomically, only at a symbol-block boundary. After the swap, decoder output valid is masked for a fixed flush window so that no mixed-tap symbols reach downstream logic.

Parameters:
NUM_TAPS, 14, number of FFE taps; must match the decoder
TAP_W, 8, signed tap width
ADDR_W, 4, tap address width; requires 2^ADDR_W >= NUM_TAPS
CURSOR_IDX, 0, index of the tap that resets to unity
UNITY, 64, reset value of the cursor tap; all other taps reset to 0
FLUSH_CYCLES, 4, decoder pipeline depth; number of cycles output valid is masked after a swap
MAX_WAIT, 1024, maximum cycles spent waiting for a boundary before a forced swap

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
io_wr_valid  input  1  tap write request
io_wr_ready  output  1  tap write accepted when valid && ready
io_wr_addr  input  ADDR_W  tap index
io_wr_data  input  TAP_W  signed tap value
io_commit  input  1  single-cycle pulse requesting a shadow-to-active swap
io_boundary  input  1  symbol-block boundary strobe from the datapath
io_rxValid_in  input  1  decoder io_rxValid
io_rxValid_out  output  1  gated valid passed downstream
io_taps_0 .. io_taps_13  output  TAP_W each  active taps, wired to decoder io_taps_N
io_busy  output  1  high whenever the FSM is not IDLE
io_commit_done  output  1  single-cycle pulse when a commit completes
io_err  output  1  sticky error flag

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - Shadow and active banks: [CURSOR_IDX] = UNITY, all other taps = 0.
  - io_err = 0, io_commit_done = 0, io_busy = 0, io_wr_ready = 1, all counters = 0.
  - Reset asserted mid-commit aborts the commit; no done pulse is produced.
- FSM states: IDLE, WAIT_BND, SWAP, FLUSH. The state register is updated at the clock edge.
- io_wr_ready = 1 in IDLE and FLUSH; 0 in WAIT_BND and SWAP. The pending shadow image is frozen once a commit is accepted.
- Accepted write:
  - addr < NUM_TAPS: shadow[addr] <= data at the next edge.
  - addr >= NUM_TAPS: the write is consumed, shadow is unchanged, io_err is set.
- IDLE:
  - io_commit=1 moves to WAIT_BND and clears the wait counter.
  - A write accepted in the same cycle as the commit is included in the swap.
- WAIT_BND:
  - io_boundary=1 moves to SWAP.
  - Otherwise the wait counter increments. When it reaches MAX_WAIT-1, move to SWAP anyway and set io_err.
  - io_boundary is ignored during the commit cycle itself.
- SWAP (exactly 1 cycle): active <= shadow for all taps simultaneously; next state is FLUSH with the flush counter cleared.
- FLUSH:
  - Lasts FLUSH_CYCLES cycles, then moves to IDLE.
  - io_commit_done = 1 for exactly the first IDLE cycle after FLUSH (registered).
- Commit timing: commit at cycle t, boundary at cycle b >= t+1:
  - SWAP at b+1.
  - New io_taps visible from b+2.
  - FLUSH spans b+2 .. b+1+FLUSH_CYCLES.
  - io_commit_done at b+2+FLUSH_CYCLES.
- io_commit outside IDLE is ignored; no queueing and no error.
- io_rxValid_out = io_rxValid_in & (state != FLUSH). This is combinational, with zero latency. Outputs from the old taps during WAIT_BND and SWAP remain valid.
- io_taps_N are driven directly from active-bank registers and change only on the SWAP edge.
- io_err clears only on reset or on the next io_commit_done.
  - If a new error and io_commit_done occur in the same cycle, set wins.
  - A forced swap sets io_err in the same cycle the FSM enters SWAP, so the following io_commit_done does not clear it.
- No arithmetic is performed on tap values: they are stored and forwarded bit-exactly as signed TAP_W.

Decomposition:
- Package ffe_cfg_pkg holds:
  - NUM_TAPS, TAP_W and ADDR_W constants.
  - A tap_t typedef (logic signed [TAP_W-1:0]).
  - The state enum {IDLE, WAIT_BND, SWAP, FLUSH}.
  - A default_tap(idx) function.
- Sub-module ffe_tap_bank holds the shadow and active arrays.
  - Inputs: write strobe, address, data, swap.
  - Output: active array.
- ffe_tap_controller contains the FSM, the wait and flush counters, and the valid gating.

Test Plan:
- Reset check: after reset, io_taps_0=64, io_taps_1..13=0, io_busy=0, io_wr_ready=1, io_err=0.
- Normal commit:
  - Stimulus: write taps 0..13 = {10,-3,2,0,...,0,-1}, commit at t, boundary at t+5.
  - Required: io_taps unchanged through t+6, new values at t+7; io_rxValid_out=0 for t+7..t+10; io_commit_done pulses at t+11.
- Write during WAIT_BND:
  - Stimulus: commit, then write addr 3 = 55 held valid.
  - Required: io_wr_ready=0 until FLUSH; write accepted in FLUSH; active tap3 keeps its old value; shadow tap3=55 takes effect on the next commit.
- Bad address:
  - Stimulus: write addr 14 = 7.
  - Required: write accepted, banks unchanged, io_err=1; io_err stays 1 until io_commit_done of the next commit.
- Boundary timeout:
  - Stimulus: MAX_WAIT=8, commit, no boundary.
  - Required: SWAP 8 cycles after WAIT_BND entry, io_err=1, io_commit_done still pulses.
- Reset mid-FLUSH:
  - Stimulus: assert reset during the second FLUSH cycle.
  - Required: next cycle state=IDLE, taps back to defaults, no io_commit_done, io_rxValid_out follows io_rxValid_in.
